// File: rtl/intra_block_scheduler.sv
// intra_block_scheduler
//   Raster-order block dispatcher for one frame plane. Walks a cursor over the
//   plane in BLK_W x BLK_H steps and offers each block coordinate to one idle
//   intra prediction engine through a valid/ready handshake. It tracks a busy
//   bit per engine and raises done after the last block has been issued and
//   every engine has reported completion.
//
//   Optional build macro: SCHED_RR_EN
//     defined   -> round-robin engine selection. The search starts after the
//                  last granted engine; the pointer resets to engine 0.
//     undefined -> fixed priority. The lowest-index idle engine wins.
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   start          frame start pulse (honoured in IDLE only)
//   frame_busy     frame in progress
//   done           frame complete, held until the next accepted start
//   eng_req_valid  one-hot offer per engine
//   eng_req_ready  per-engine accept
//   eng_coord      per-engine {y, x}, x in the low COORD_W bits
//   eng_done       per-engine completion pulse
//   issued_count   blocks dispatched in the current frame

// Per-engine busy tracker. A transfer sets the bit; a completion pulse clears it.
// A transfer only targets an idle engine, so a done pulse arriving in the same
// cycle is necessarily spurious and set has priority.
module intra_block_scheduler_eng (
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic busy
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  busy <= 1'b0;
    else if (set)  busy <= 1'b1;
    else if (clr)  busy <= 1'b0;
endmodule

module intra_block_scheduler #(
  parameter int NUM_ENGINES = 2,
  parameter int FRAME_W     = 1280,
  parameter int FRAME_H     = 720,
  parameter int BLK_W       = 4,
  parameter int BLK_H       = 4,
  parameter int COORD_W     = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  output logic                               frame_busy,
  output logic                               done,
  output logic [NUM_ENGINES-1:0]             eng_req_valid,
  input  logic [NUM_ENGINES-1:0]             eng_req_ready,
  output logic [NUM_ENGINES*2*COORD_W-1:0]   eng_coord,
  input  logic [NUM_ENGINES-1:0]             eng_done,
  output logic [2*COORD_W-1:0]               issued_count
);
  localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [COORD_W-1:0]   X_LAST = COORD_W'(FRAME_W - BLK_W);
  localparam logic [COORD_W-1:0]   Y_LAST = COORD_W'(FRAME_H - BLK_H);
  localparam logic [COORD_W-1:0]   X_STEP = COORD_W'(BLK_W);
  localparam logic [COORD_W-1:0]   Y_STEP = COORD_W'(BLK_H);
  localparam logic [2*COORD_W-1:0] CNT_ONE = (2*COORD_W)'(1);

  if (NUM_ENGINES < 1 || NUM_ENGINES > 8) begin : g_bad_eng
    $error("intra_block_scheduler: NUM_ENGINES must be 1..8");
  end
  if ((FRAME_W % BLK_W) != 0 || (FRAME_H % BLK_H) != 0) begin : g_bad_dim
    $error("intra_block_scheduler: frame dimensions must be block multiples");
  end
  if (64'(FRAME_W) >= (64'd1 << COORD_W) || 64'(FRAME_H) >= (64'd1 << COORD_W)) begin : g_bad_cw
    $error("intra_block_scheduler: frame dimensions exceed COORD_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [NUM_ENGINES-1:0] busy, xfer_vec, idle_mask, sel_oh;
  logic [IW-1:0]          sel_idx;
  logic                   sel_any, xfer, last_xfer, offer;
  logic [COORD_W-1:0]     cx, cy, nx, ny, off_x, off_y;

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
    intra_block_scheduler_eng u_eng (
      .clk    (clk),
      .reset_n(reset_n),
      .set    (xfer_vec[g]),
      .clr    (eng_done[g]),
      .busy   (busy[g])
    );
  end

  assign xfer_vec  = eng_req_valid & eng_req_ready;
  assign xfer      = |xfer_vec;
  assign last_xfer = xfer && (cx == X_LAST) && (cy == Y_LAST);
  // The engine taking a block this cycle is about to go busy, so it is not
  // a candidate for the back-to-back offer.
  assign idle_mask = ~busy & ~xfer_vec;

  assign nx    = (cx == X_LAST) ? '0 : cx + X_STEP;
  assign ny    = (cx == X_LAST) ? cy + Y_STEP : cy;
  // An offer made on a transfer edge carries the already-advanced cursor.
  assign off_x = xfer ? nx : cx;
  assign off_y = xfer ? ny : cy;

`ifdef SCHED_RR_EN
  logic [IW-1:0] rr_ptr;
  always_comb begin
    int j;
    j       = 0;
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_ENGINES) j = j - NUM_ENGINES;
      if (!sel_any && idle_mask[j]) begin
        sel_any = 1'b1;
        sel_idx = IW'(j);
      end
    end
  end
`else
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = NUM_ENGINES-1; k >= 0; k--) begin
      if (idle_mask[k]) begin
        sel_any = 1'b1;
        sel_idx = IW'(k);
      end
    end
  end
`endif

  assign sel_oh = sel_any ? (NUM_ENGINES'(1) << sel_idx) : '0;
  assign offer  = (state == RUN) && ((eng_req_valid == '0) || xfer) && !last_xfer && sel_any;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)        state_nxt = RUN;
      RUN:     if (last_xfer)    state_nxt = DRAIN;
      DRAIN:   if (busy == '0)   state_nxt = FIN;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx            <= '0;
      cy            <= '0;
      issued_count  <= '0;
      done          <= 1'b0;
      frame_busy    <= 1'b0;
      eng_req_valid <= '0;
      eng_coord     <= '0;
`ifdef SCHED_RR_EN
      rr_ptr        <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        cx           <= '0;
        cy           <= '0;
        issued_count <= '0;
        done         <= 1'b0;
        frame_busy   <= 1'b1;
      end
      if (state == DRAIN && busy == '0) begin
        done       <= 1'b1;
        frame_busy <= 1'b0;
      end
      if (xfer) begin
        cx           <= nx;
        cy           <= ny;
        issued_count <= issued_count + CNT_ONE;
      end
      if (offer) begin
        eng_req_valid <= sel_oh;
        eng_coord[int'(sel_idx)*2*COORD_W +: 2*COORD_W] <= {off_y, off_x};
`ifdef SCHED_RR_EN
        rr_ptr <= (int'(sel_idx) == NUM_ENGINES-1) ? '0 : sel_idx + IW'(1);
`endif
      end else if (xfer) begin
        eng_req_valid <= '0;
      end
    end
  end
endmodule

// File: tb/tb_intra_block_scheduler.sv
module tb_intra_block_scheduler;
  localparam int N = 2, FW = 16, FH = 8, BW = 4, BH = 4, CW = 16;
  localparam int COLS = FW / BW, TOTAL = (FW / BW) * (FH / BH);
  localparam int N2 = 4;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [N-1:0] ready = '0, edone = '0, valid;
  logic [N*2*CW-1:0] coord;
  logic fbusy, done;
  logic [2*CW-1:0] issued;

  logic start2 = 1'b0;
  logic [N2-1:0] ready2 = '1, edone2 = '0, valid2;
  logic [N2*2*CW-1:0] coord2;
  logic fbusy2, done2;
  logic [2*CW-1:0] issued2;

  always #5 clk = ~clk;

  intra_block_scheduler #(.NUM_ENGINES(N), .FRAME_W(FW), .FRAME_H(FH),
                          .BLK_W(BW), .BLK_H(BH), .COORD_W(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_busy(fbusy), .done(done),
    .eng_req_valid(valid), .eng_req_ready(ready), .eng_coord(coord),
    .eng_done(edone), .issued_count(issued));

  intra_block_scheduler #(.NUM_ENGINES(N2), .FRAME_W(16), .FRAME_H(16),
                          .BLK_W(8), .BLK_H(8), .COORD_W(CW)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start2), .frame_busy(fbusy2), .done(done2),
    .eng_req_valid(valid2), .eng_req_ready(ready2), .eng_coord(coord2),
    .eng_done(edone2), .issued_count(issued2));

  int tests = 0, fails = 0;
  int cyc = 0, mode = 0, stall_end = 0;
  logic rst_req = 1'b0, start_req = 1'b0, start2_req = 1'b0;
  int timer[N], timer2[N2];

  // behavioural model: frame phase, per-engine busy, pending offer
  // (engine only; the offered block is always block number m_issued)
  int m_phase;   // 0 idle, 1 run, 2 drain, 3 fin
  bit m_busy[N];
  bit m_ov;
  int m_oe, m_issued, m_ptr;
  bit m_done, m_fbusy;

  // DUT transfer logs
  int xlog[$], ylog[$], elog[$];
  int x2log[$], y2log[$], e2log[$], c2log[$];
  int last_done_cyc = 0, done_rise_cyc = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_ov = 0; m_oe = 0; m_issued = 0; m_ptr = 0;
    m_done = 0; m_fbusy = 0;
    for (int i = 0; i < N; i++) m_busy[i] = 0;
  endtask

  task automatic m_step();
    bit xfer, last, all_idle;
    bit nb[N], elig[N];
    int sel, j;
    xfer = m_ov && ready[m_oe];
    last = xfer && (m_issued == TOTAL - 1);
    all_idle = 1;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) all_idle = 0;
      nb[i]   = m_busy[i] && !edone[i];
      elig[i] = !m_busy[i] && !(xfer && m_oe == i);
    end
    if (xfer) begin
      nb[m_oe] = 1;
      timer[m_oe] = (mode == 1) ? int'($urandom_range(1, 5)) : 2;
    end
    case (m_phase)
      0: if (start) begin m_phase = 1; m_issued = 0; m_done = 0; m_fbusy = 1; end
      1: begin
        if (xfer) m_issued++;
        if (last) begin
          m_phase = 2; m_ov = 0;
        end else if (!m_ov || xfer) begin
          sel = -1;
          for (int k = 0; k < N; k++) begin
`ifdef SCHED_RR_EN
            j = (m_ptr + k) % N;
`else
            j = k;
`endif
            if (sel < 0 && elig[j]) sel = j;
          end
          if (sel >= 0) begin m_ov = 1; m_oe = sel; m_ptr = (sel + 1) % N; end
          else m_ov = 0;
        end
      end
      2: if (all_idle) begin m_phase = 3; m_done = 1; m_fbusy = 0; end
      default: m_phase = 0;
    endcase
    for (int i = 0; i < N; i++) m_busy[i] = nb[i];
  endtask

  task automatic compare();
    logic [N-1:0] ev;
    logic [CW-1:0] ex, ey;
    ev = m_ov ? (N'(1) << m_oe) : '0;
    ex = CW'((m_issued % COLS) * BW);
    ey = CW'((m_issued / COLS) * BH);
    check("eng_req_valid", 64'(valid), 64'(ev));
    if (m_ov) check("eng_coord", 64'(coord[m_oe*2*CW +: 2*CW]), 64'({ey, ex}));
    check("issued_count", 64'(issued), 64'(m_issued));
    check("done", 64'(done), 64'(m_done));
    check("frame_busy", 64'(fbusy), 64'(m_fbusy));
    for (int i = 0; i < N; i++)
      if (valid[i] && ready[i]) begin
        xlog.push_back(int'(coord[i*2*CW +: CW]));
        ylog.push_back(int'(coord[i*2*CW+CW +: CW]));
        elog.push_back(i);
      end
    if (|edone) last_done_cyc = cyc;
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
    for (int i = 0; i < N2; i++)
      if (valid2[i] && ready2[i]) begin
        x2log.push_back(int'(coord2[i*2*CW +: CW]));
        y2log.push_back(int'(coord2[i*2*CW+CW +: CW]));
        e2log.push_back(i);
        c2log.push_back(cyc);
        timer2[i] = 2;
      end
  endtask

  task automatic drive();
    reset_n = rst_req;
    if (!reset_n) m_reset();
    start = start_req; start_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      edone[i] = 1'b0;
      if (timer[i] > 0) begin timer[i]--; if (timer[i] == 0) edone[i] = 1'b1; end
      case (mode)
        1: begin
          ready[i] = ($urandom_range(0, 9) < 7);
          if (!edone[i] && !m_busy[i] && $urandom_range(0, 9) == 0) edone[i] = 1'b1;
        end
        2: ready[i] = (i != 0) || (cyc >= stall_end);
        default: ready[i] = 1'b1;
      endcase
    end
    if (mode == 1 && $urandom_range(0, 19) == 0) start = 1'b1;
    start2 = start2_req; start2_req = 1'b0;
    for (int i = 0; i < N2; i++) begin
      edone2[i] = 1'b0;
      if (timer2[i] > 0) begin timer2[i]--; if (timer2[i] == 0) edone2[i] = 1'b1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    drive();
    @(negedge clk);
    if (reset_n) begin compare(); m_step(); end
  endtask

  task automatic wait_frame(input int bound);
    int n;
    n = 0;
    while (!(m_phase == 0 && m_done) && n < bound) begin cycle(); n++; end
    check("frame_timeout", 64'(n >= bound), 64'd0);
  endtask

  task automatic clear_logs();
    xlog.delete(); ylog.delete(); elog.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) timer[i] = 0;
    for (int i = 0; i < N2; i++) timer2[i] = 0;
    m_reset();
    repeat (3) cycle();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_coord", 64'(coord), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_busy", 64'(fbusy), 64'd0);
    check("rst_issued", 64'(issued), 64'd0);
    rst_req = 1'b1;
    cycle();

    // frame 1: ready high, done two cycles after each transfer
    mode = 0; clear_logs();
    start_req = 1'b1;
    cycle();
    wait_frame(200);
    check("f1_count", 64'(xlog.size()), 64'd8);
    if (xlog.size() == 8)
      for (int k = 0; k < 8; k++) begin
        check("f1_x", 64'(xlog[k]), 64'((k % 4) * 4));
        check("f1_y", 64'(ylog[k]), 64'((k / 4) * 4));
      end
    if (elog.size() >= 2) begin
      check("first_grant_eng", 64'(elog[0]), 64'd0);
      check("second_grant_eng", 64'(elog[1]), 64'd1);
    end
    check("f1_issued", 64'(issued), 64'd8);
    check("f1_done", 64'(done), 64'd1);
    check("done_after_last_eng_done", 64'(done_rise_cyc > last_done_cyc), 64'd1);

    // stall: engine 0 holds ready low while its first offer is pending
    mode = 2; clear_logs();
    stall_end = cyc + 9;
    start_req = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("stall_valid", 64'(valid), 64'd1);
      check("stall_coord", 64'(coord[2*CW-1:0]), 64'd0);
    end
    wait_frame(200);
    check("stall_issued", 64'(issued), 64'd8);

    // start during RUN ignored, then reset mid-frame after 3 transfers
    mode = 0; clear_logs();
    start_req = 1'b1;
    cycle();
    n = 0;
    while (m_issued < 3 && n < 100) begin cycle(); n++; end
    check("reach3_timeout", 64'(n >= 100), 64'd0);
    start_req = 1'b1;
    cycle();
    check("restart_ignored_busy", 64'(fbusy), 64'd1);
    rst_req = 1'b0;
    cycle();
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_coord", 64'(coord), 64'd0);
    check("midrst_issued", 64'(issued), 64'd0);
    check("midrst_frame_busy", 64'(fbusy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst_req = 1'b1;
    cycle();
    clear_logs();
    start_req = 1'b1;
    cycle();
    cycle();
    check("restart_issued", 64'(issued), 64'd0);
    n = 0;
    while (xlog.size() == 0 && n < 50) begin cycle(); n++; end
    check("restart_xfer_timeout", 64'(n >= 50), 64'd0);
    if (xlog.size() > 0) begin
      check("restart_x", 64'(xlog[0]), 64'd0);
      check("restart_y", 64'(ylog[0]), 64'd0);
    end
    wait_frame(200);

    // randomized ready, completion latency, spurious done and stray starts
    mode = 1;
    repeat (3000) cycle();
    mode = 0;
    if (m_phase != 0) wait_frame(400);

    // 8x8 blocks, 16x16 plane, four engines
    start2_req = 1'b1;
    cycle();
    n = 0;
    while (!done2 && n < 100) begin cycle(); n++; end
    check("p8_done_timeout", 64'(n >= 100), 64'd0);
    check("p8_count", 64'(x2log.size()), 64'd4);
    if (x2log.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check("p8_x", 64'(x2log[k]), 64'((k % 2) * 8));
        check("p8_y", 64'(y2log[k]), 64'((k / 2) * 8));
        check("p8_eng", 64'(e2log[k]), 64'(k));
        check("p8_consecutive", 64'(c2log[k] - c2log[0]), 64'(k));
      end
    check("p8_issued", 64'(issued2), 64'd4);
    check("p8_frame_busy", 64'(fbusy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
